iterative_exec_unit: RTL and testbench

- Multi-cycle integer execute unit for the RV32I core.
- Consumes the 4-bit ALU operation code and branch-invert flag produced by the ALU control decoder, plus two operands. Produces result, zero flag and branch decision.
- Logical/arithmetic/compare ops finish in one cycle. Shifts run one bit per cycle, so no barrel shifter is needed.
- Sits between decode/operand fetch and writeback/PC-select. Valid/ready handshake on both sides.

---
 rtl/iterative_exec_unit.sv | 172 +++++++++++++++++
 tb/tb_iterative_exec_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/iterative_exec_unit.sv
// Multi-cycle RV32I execute unit: single-cycle logic/arith/compare ops and
// bit-serial shifts, with valid/ready handshakes on both the request and result sides.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a request; in_ready=1
// S_SHIFT  | shifting one bit per cycle; count_q holds the remaining bits
// S_RESULT | result, zero and branch_taken held; out_valid=1 until out_ready
module iterative_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             invert,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             branch_taken,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q;
    logic             inv_q;
    logic [WIDTH-1:0] shift_q;
    logic [SHW-1:0]   count_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             branch_q;

    logic             accept;
    logic             is_shift;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] shift_next;
    logic             last_shift;

    assign shamt      = b[SHW-1:0];
    assign is_shift   = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    assign accept     = in_valid && (state_q == S_IDLE);
    assign last_shift = (count_q == SHW'(1));

    always_comb begin
        alu_res = '0;
        case (op)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: alu_res = '0;
        endcase
    end

    // A zero-distance shift passes operand A straight through.
    assign load_val = is_shift ? a : alu_res;

    always_comb begin
        shift_next = shift_q;
        case (op_q)
            OP_SLL:  shift_next = {shift_q[WIDTH-2:0], 1'b0};
            OP_SRL:  shift_next = {1'b0, shift_q[WIDTH-1:1]};
            OP_SRA:  shift_next = {shift_q[WIDTH-1], shift_q[WIDTH-1:1]};
            default: shift_next = shift_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    if (is_shift && (shamt != '0)) begin
                        state_d = S_SHIFT;
                    end else begin
                        state_d = S_RESULT;
                    end
                end
            end
            S_SHIFT: begin
                if (last_shift) begin
                    state_d = S_RESULT;
                end
            end
            S_RESULT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= '0;
            inv_q    <= 1'b0;
            shift_q  <= '0;
            count_q  <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            branch_q <= 1'b0;
        end else if (accept) begin
            op_q  <= op;
            inv_q <= invert;
            if (is_shift && (shamt != '0)) begin
                shift_q <= a;
                count_q <= shamt;
            end else begin
                result_q <= load_val;
                zero_q   <= (load_val == '0);
                branch_q <= (load_val == '0) ^ invert;
            end
        end else if (state_q == S_SHIFT) begin
            shift_q <= shift_next;
            count_q <= count_q - SHW'(1);
            if (last_shift) begin
                result_q <= shift_next;
                zero_q   <= (shift_next == '0);
                branch_q <= (shift_next == '0) ^ inv_q;
            end
        end
    end

    assign result       = result_q;
    assign zero         = zero_q;
    assign branch_taken = branch_q;

endmodule

// File: tb/tb_iterative_exec_unit.sv
// Directed-vector bench for iterative_exec_unit: hand-computed results,
// latencies, backpressure and mid-operation reset.
module tb_iterative_exec_unit;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic        invert;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        branch_taken;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    iterative_exec_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .op           (op),
        .invert       (invert),
        .a            (a),
        .b            (b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .zero         (zero),
        .branch_taken (branch_taken),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic inv, input logic [31:0] va, input logic [31:0] vb);
        op       = o;
        invert   = inv;
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        op       = 4'd0;
        a        = 32'hDEAD_BEEF;
        b        = 32'h0000_0003;
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_drop_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [3:0] o, input logic inv,
                          input logic [31:0] va, input logic [31:0] vb, input int exp_lat,
                          input logic [31:0] exp_res, input logic exp_zero, input logic exp_br);
        int lat;
        logic stall_bad;
        lat = 1;
        stall_bad = 1'b0;
        issue(o, inv, va, vb);
        while (!out_valid && lat < 64) begin
            if (in_ready || !busy) stall_bad = 1'b1;
            step();
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_stall"}, {31'd0, stall_bad}, 32'd0);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_zero});
        check({tag, "_branch"}, {31'd0, branch_taken}, {31'd0, exp_br});
        consume(tag);
    endtask

    initial begin
        logic stable_bad;
        logic spurious;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 4'd0;
        invert    = 1'b0;
        a         = '0;
        b         = '0;
        step();
        step();
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd1);
        check("rst_branch", {31'd0, branch_taken}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        reset_n = 1'b1;
        step();

        run_op("add_wrap", 4'd2, 1'b0, 32'h7FFF_FFFF, 32'd1, 1, 32'h8000_0000, 1'b0, 1'b0);
        run_op("sub_beq",  4'd3, 1'b0, 32'd5, 32'd5, 1, 32'd0, 1'b1, 1'b1);
        run_op("slt_blt",  4'd6, 1'b1, 32'hFFFF_FFFF, 32'd1, 1, 32'd1, 1'b0, 1'b1);
        run_op("sltu_bgeu", 4'd7, 1'b0, 32'hFFFF_FFFF, 32'd1, 1, 32'd0, 1'b1, 1'b1);
        run_op("and",      4'd0, 1'b0, 32'hFF00_FF00, 32'h0F0F_0F0F, 1, 32'h0F00_0F00, 1'b0, 1'b0);
        run_op("or",       4'd1, 1'b1, 32'h1200_0000, 32'h0000_0034, 1, 32'h1200_0034, 1'b0, 1'b1);
        run_op("sra31",    4'd9, 1'b0, 32'h8000_0000, 32'd31, 32, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("sll0",     4'd5, 1'b0, 32'd1, 32'd0, 1, 32'd1, 1'b0, 1'b0);
        run_op("sll4",     4'd5, 1'b0, 32'h8000_0001, 32'd4, 5, 32'h0000_0010, 1'b0, 1'b0);
        run_op("srl3",     4'd8, 1'b1, 32'h8000_0000, 32'd3, 4, 32'h1000_0000, 1'b0, 1'b1);
        run_op("rsvd12",   4'd12, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1, 32'd0, 1'b1, 1'b0);

        // Backpressure with a queued request held on in_valid.
        issue(4'd4, 1'b0, 32'hF0F0_F0F0, 32'hFFFF_0000);
        op       = 4'd2;
        a        = 32'd1;
        b        = 32'd2;
        in_valid = 1'b1;
        stable_bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (!out_valid || result !== 32'h0F0F_F0F0 || in_ready) stable_bad = 1'b1;
            step();
        end
        check("bp_held", {31'd0, stable_bad}, 32'd0);
        check("bp_result", result, 32'h0F0F_F0F0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_idle_valid", {31'd0, out_valid}, 32'd0);
        check("bp_idle_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_queued_valid", {31'd0, out_valid}, 32'd1);
        check("bp_queued_result", result, 32'd3);
        consume("bp_queued");

        // Reset during a shift discards it.
        issue(4'd8, 1'b0, 32'hFFFF_FFFF, 32'd20);
        for (int i = 0; i < 6; i++) step();
        check("mid_busy_before", {31'd0, busy}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_result", result, 32'd0);
        check("mid_rst_zero", {31'd0, zero}, 32'd1);
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        step();
        reset_n = 1'b1;
        spurious = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (out_valid || !in_ready) spurious = 1'b1;
            step();
        end
        check("mid_rst_no_valid", {31'd0, spurious}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no_finish expected finish");
        $fatal(1);
    end
endmodule
